max11100_sampler: RTL and testbench

//  Scheduler/controller for the max11100 SPI ADC front end. A programmable period timer triggers

---
 rtl/max11100_sampler.sv | 164 ++++++++++++++++
 tb/tb_max11100_sampler.sv | 375 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/max11100_sampler.sv
// Periodic conversion scheduler for the max11100 ADC: triggers conversions on a
// programmable period, averages 2^AVG_LOG2 results and streams them out valid/ready.
module max11100_sampler #(
    parameter int PERIOD_W       = 16,
    parameter int AVG_LOG2       = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                enable,
    input  logic [PERIOD_W-1:0] period,
    output logic                adc_trigger,
    input  logic [15:0]         adc_data,
    input  logic                adc_data_ready,
    output logic [15:0]         sample_data,
    output logic                sample_valid,
    input  logic                sample_ready,
    output logic                busy,
    output logic                overrun,
    output logic                timeout_err,
    input  logic                clear_err
);

    localparam int ACC_W = 16 + AVG_LOG2;
    localparam int CNT_W = AVG_LOG2 + 1;
    localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(1 << AVG_LOG2);
    // The trigger cycle counts toward the budget, so WAIT aborts one count early.
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 2);

    typedef enum logic [1:0] {IDLE, TRIG, WAIT, DONE} state_t;

    state_t              state_reg, state_next;
    logic [PERIOD_W-1:0] timer_reg, timer_next;
    logic                tick;
    logic                dr_q;
    logic                dr_rise;
    logic [ACC_W-1:0]    acc_reg, acc_next;
    logic [CNT_W-1:0]    count_reg, count_next;
    logic [TO_W-1:0]     to_cnt_reg, to_cnt_next;
    logic [15:0]         data_reg, data_next;
    logic                valid_reg, valid_next;
    logic                overrun_reg, overrun_next;
    logic                timeout_reg, timeout_next;
    logic                transfer;
    logic                overrun_set;
    logic                timeout_set;

    assign dr_rise = adc_data_ready & ~dr_q;

    // Countdown timer: zero while disabled, so the first enabled cycle ticks.
    always_comb begin
        tick       = enable && (timer_reg == '0);
        timer_next = timer_reg;
        if (!enable) begin
            timer_next = '0;
        end else if (tick) begin
            timer_next = (period == '0) ? '0 : period - PERIOD_W'(1);
        end else begin
            timer_next = timer_reg - PERIOD_W'(1);
        end
    end

    always_comb begin
        state_next   = state_reg;
        acc_next     = acc_reg;
        count_next   = count_reg;
        to_cnt_next  = to_cnt_reg;
        data_next    = data_reg;
        valid_next   = valid_reg;
        overrun_set  = 1'b0;
        timeout_set  = 1'b0;
        adc_trigger  = 1'b0;
        transfer     = valid_reg & sample_ready;

        if (transfer) begin
            valid_next = 1'b0;
        end
        if (tick && state_reg != IDLE) begin
            overrun_set = 1'b1;
        end

        case (state_reg)
            IDLE: begin
                if (!enable) begin
                    acc_next   = '0;
                    count_next = '0;
                end
                if (tick) begin
                    state_next = TRIG;
                end
            end
            TRIG: begin
                adc_trigger = 1'b1;
                to_cnt_next = '0;
                state_next  = WAIT;
            end
            WAIT: begin
                if (dr_rise) begin
                    acc_next   = acc_reg + ACC_W'(adc_data);
                    count_next = count_reg + CNT_W'(1);
                    state_next = ((count_reg + CNT_W'(1)) == CNT_FULL) ? DONE : IDLE;
                end else if (to_cnt_reg == TO_LAST) begin
                    timeout_set = 1'b1;
                    acc_next    = '0;
                    count_next  = '0;
                    state_next  = IDLE;
                end else begin
                    to_cnt_next = to_cnt_reg + TO_W'(1);
                end
            end
            DONE: begin
                data_next  = acc_reg[AVG_LOG2 +: 16];
                valid_next = 1'b1;
                if (valid_reg && !transfer) begin
                    overrun_set = 1'b1;
                end
                acc_next   = '0;
                count_next = '0;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // Set beats clear when both land in the same cycle.
        overrun_next = overrun_set | (overrun_reg & ~clear_err);
        timeout_next = timeout_set | (timeout_reg & ~clear_err);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg   <= IDLE;
            timer_reg   <= '0;
            dr_q        <= 1'b0;
            acc_reg     <= '0;
            count_reg   <= '0;
            to_cnt_reg  <= '0;
            data_reg    <= '0;
            valid_reg   <= 1'b0;
            overrun_reg <= 1'b0;
            timeout_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            timer_reg   <= timer_next;
            dr_q        <= adc_data_ready;
            acc_reg     <= acc_next;
            count_reg   <= count_next;
            to_cnt_reg  <= to_cnt_next;
            data_reg    <= data_next;
            valid_reg   <= valid_next;
            overrun_reg <= overrun_next;
            timeout_reg <= timeout_next;
        end
    end

    assign sample_data  = data_reg;
    assign sample_valid = valid_reg;
    assign busy         = (state_reg != IDLE);
    assign overrun      = overrun_reg;
    assign timeout_err  = timeout_reg;

endmodule

// File: tb/tb_max11100_sampler.sv
// Bench for max11100_sampler: a behavioural ADC, a 4-sample averaging scoreboard,
// directed scenarios and a randomized run.
module tb_max11100_sampler;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        enable = 1'b0;
    logic [15:0] period = 16'd0;
    logic        adc_trigger;
    logic [15:0] adc_data = 16'd0;
    logic        adc_data_ready = 1'b0;
    logic [15:0] sample_data;
    logic        sample_valid;
    logic        sample_ready = 1'b1;
    logic        busy;
    logic        overrun;
    logic        timeout_err;
    logic        clear_err = 1'b0;

    always #5 clk = ~clk;

    max11100_sampler #(
        .PERIOD_W(16),
        .AVG_LOG2(2),
        .TIMEOUT_CYCLES(1024)
    ) dut (
        .clk(clk),
        .resetn(resetn),
        .enable(enable),
        .period(period),
        .adc_trigger(adc_trigger),
        .adc_data(adc_data),
        .adc_data_ready(adc_data_ready),
        .sample_data(sample_data),
        .sample_valid(sample_valid),
        .sample_ready(sample_ready),
        .busy(busy),
        .overrun(overrun),
        .timeout_err(timeout_err),
        .clear_err(clear_err)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    // ADC model state
    int          lat = 10;
    bit          mute = 1'b0;
    int          adc_cnt = 0;
    int          dr_hold = 0;
    bit          conv_live = 1'b0;
    logic [15:0] data_q[$];
    int          raise_cyc = -1;

    int trig_count = 0;
    int last_trig = -1;
    int trig_interval = 0;

    // Averaging reference: every four accepted conversions give sum/4.
    int unsigned part_sum = 0;
    int          part_n = 0;
    logic [15:0] exp_q[$];
    bit          sb_on = 1'b1;
    int          ready_mode = 0;
    int          xfer_count = 0;
    logic [15:0] last_xfer = 16'd0;
    bit          prev_valid = 1'b0;
    int          valid_rise_cyc = -1;
    logic [15:0] prev_data = 16'd0;
    bit          prev_stall = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_push(input logic [15:0] v);
        part_sum += 32'(v);
        part_n++;
        if (part_n == 4) begin
            exp_q.push_back(16'(part_sum >> 2));
            part_sum = 0;
            part_n = 0;
        end
    endtask

    task automatic step();
        logic [15:0] v;
        @(negedge clk);
        cyc++;
        if (adc_trigger) begin
            if (last_trig >= 0) trig_interval = cyc - last_trig;
            last_trig = cyc;
            trig_count++;
        end
        if (sample_valid && !prev_valid) valid_rise_cyc = cyc;
        prev_valid = sample_valid;
        if (sb_on && prev_stall) begin
            chk("hold_valid", 32'(sample_valid), 32'd1);
            chk("hold_data", 32'(sample_data), 32'(prev_data));
        end

        if (dr_hold > 0) begin
            dr_hold--;
            if (dr_hold == 0) adc_data_ready = 1'b0;
        end
        if (adc_cnt > 0) begin
            adc_cnt--;
            if (adc_cnt == 0) begin
                if (data_q.size() > 0) v = data_q.pop_front();
                else v = 16'($urandom);
                adc_data = v;
                adc_data_ready = 1'b1;
                dr_hold = 2;
                raise_cyc = cyc;
                if (conv_live) model_push(v);
            end
        end
        if (adc_trigger && resetn) begin
            if (mute) begin
                part_sum = 0;
                part_n = 0;
            end else begin
                adc_cnt = lat;
                conv_live = 1'b1;
            end
        end
        if (!enable && !busy && adc_cnt == 0 && dr_hold == 0) begin
            part_sum = 0;
            part_n = 0;
        end

        case (ready_mode)
            0:       sample_ready = 1'b1;
            1:       sample_ready = ($urandom_range(0, 3) != 0);
            default: sample_ready = 1'b0;
        endcase
        prev_stall = sample_valid && !sample_ready;
        prev_data = sample_data;
        if (sample_valid && sample_ready) begin
            xfer_count++;
            last_xfer = sample_data;
            if (sb_on) begin
                if (exp_q.size() == 0) chk("xfer_unexpected", 32'(exp_q.size()), 32'd1);
                else chk("xfer_data", 32'(sample_data), 32'(exp_q.pop_front()));
            end
        end
    endtask

    task automatic wait_trig(input string tag, input int budget);
        int start;
        bit seen;
        start = trig_count;
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            step();
            if (trig_count != start) begin
                seen = 1'b1;
                break;
            end
        end
        chk(tag, 32'(seen), 32'd1);
    endtask

    task automatic wait_quiet(input string tag, input int budget);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (!busy && adc_cnt == 0 && dr_hold == 0) begin
                seen = 1'b1;
                break;
            end
            step();
        end
        chk(tag, 32'(seen), 32'd1);
        repeat (4) step();
    endtask

    task automatic enter_reset();
        resetn = 1'b0;
        part_sum = 0;
        part_n = 0;
        exp_q.delete();
        data_q.delete();
        conv_live = 1'b0;
        mute = 1'b0;
        clear_err = 1'b0;
        prev_stall = 1'b0;
        last_trig = -1;
    endtask

    task automatic do_reset(input int hold);
        enter_reset();
        repeat (hold) step();
        chk("rst_outputs", 32'({adc_trigger, sample_valid, busy, overrun, timeout_err, sample_data}), 32'd0);
        resetn = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int x0;
        int t0;
        bit seen;

        do_reset(4);

        // 1: constant data, period 200
        period = 16'd200;
        lat = 50;
        for (int i = 0; i < 8; i++) data_q.push_back(16'h1234);
        ready_mode = 0;
        sb_on = 1'b1;
        x0 = xfer_count;
        enable = 1'b1;
        step();
        chk("t1_first_trig", 32'(adc_trigger), 32'd1);
        for (int k = 2; k <= 8; k++) begin
            wait_trig("t1_trig_seen", 260);
            chk("t1_interval", 32'(trig_interval), 32'd200);
        end
        enable = 1'b0;
        wait_quiet("t1_quiet", 400);
        chk("t1_xfers", 32'(xfer_count - x0), 32'd2);
        chk("t1_last", 32'(last_xfer), 32'h1234);
        chk("t1_overrun", 32'(overrun), 32'd0);

        // 2: 0x10..0x13 average, output latency
        do_reset(3);
        period = 16'd60;
        lat = 10;
        for (int i = 0; i < 4; i++) data_q.push_back(16'(16 + i));
        enable = 1'b1;
        for (int k = 0; k < 4; k++) wait_trig("t2_trig_seen", 80);
        enable = 1'b0;
        wait_quiet("t2_quiet", 100);
        chk("t2_avg", 32'(last_xfer), 32'h0011);
        chk("t2_latency", 32'(valid_rise_cyc - raise_cyc), 32'd2);

        // 3: period shorter than a conversion
        do_reset(3);
        period = 16'd4;
        lat = 20;
        x0 = xfer_count;
        enable = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            wait_trig("t3_trig_seen", 100);
            if (k > 1) begin
                chk("t3_tick_grid", 32'(trig_interval % 4), 32'd0);
                chk("t3_skipped", 32'(trig_interval > 20), 32'd1);
            end
        end
        enable = 1'b0;
        wait_quiet("t3_quiet", 100);
        chk("t3_overrun", 32'(overrun), 32'd1);
        chk("t3_xfers", 32'(xfer_count - x0), 32'd2);
        chk("t3_sb_empty", 32'(exp_q.size()), 32'd0);

        // 4: conversion timeout and retrigger
        do_reset(3);
        period = 16'd1100;
        lat = 10;
        x0 = xfer_count;
        enable = 1'b1;
        for (int k = 0; k < 2; k++) wait_trig("t4_trig_seen", 1200);
        mute = 1'b1;
        wait_trig("t4_mute_trig", 1200);
        t0 = last_trig;
        seen = 1'b0;
        for (int i = 0; i < 1100; i++) begin
            step();
            if (timeout_err) begin
                seen = 1'b1;
                break;
            end
        end
        chk("t4_timeout_seen", 32'(seen), 32'd1);
        chk("t4_timeout_delay", 32'(cyc - t0), 32'd1024);
        chk("t4_idle", 32'(busy), 32'd0);
        mute = 1'b0;
        wait_trig("t4_retrig", 200);
        chk("t4_retrig_interval", 32'(trig_interval), 32'd1100);
        for (int k = 0; k < 3; k++) wait_trig("t4_trig_seen", 1200);
        enable = 1'b0;
        wait_quiet("t4_quiet", 100);
        chk("t4_xfers", 32'(xfer_count - x0), 32'd1);
        chk("t4_sticky", 32'(timeout_err), 32'd1);
        chk("t4_no_overrun", 32'(overrun), 32'd0);
        clear_err = 1'b1;
        step();
        clear_err = 1'b0;
        chk("t4_cleared", 32'(timeout_err), 32'd0);

        // 5: unaccepted sample overwritten
        do_reset(3);
        period = 16'd40;
        lat = 8;
        ready_mode = 2;
        sb_on = 1'b0;
        for (int i = 0; i < 4; i++) data_q.push_back(16'h0100);
        for (int i = 0; i < 4; i++) data_q.push_back(16'h0F00);
        enable = 1'b1;
        for (int k = 0; k < 8; k++) wait_trig("t5_trig_seen", 60);
        enable = 1'b0;
        wait_quiet("t5_quiet", 100);
        chk("t5_valid", 32'(sample_valid), 32'd1);
        chk("t5_data", 32'(sample_data), 32'h0F00);
        chk("t5_overrun", 32'(overrun), 32'd1);
        clear_err = 1'b1;
        step();
        clear_err = 1'b0;
        chk("t5_overrun_clr", 32'(overrun), 32'd0);
        chk("t5_valid_held", 32'(sample_valid), 32'd1);
        ready_mode = 0;
        step();
        chk("t5_xfer", 32'(last_xfer), 32'h0F00);
        step();
        chk("t5_valid_drop", 32'(sample_valid), 32'd0);
        sb_on = 1'b1;

        // 6: async reset during WAIT
        do_reset(3);
        period = 16'd100;
        lat = 30;
        enable = 1'b1;
        wait_trig("t6_trig_seen", 5);
        repeat (5) step();
        chk("t6_busy", 32'(busy), 32'd1);
        enter_reset();
        #1;
        chk("t6_async", 32'({adc_trigger, sample_valid, busy, overrun, timeout_err, sample_data}), 32'd0);
        repeat (40) step();
        resetn = 1'b1;
        lat = 10;
        x0 = xfer_count;
        step();
        chk("t6_first_trig", 32'(adc_trigger), 32'd1);
        for (int k = 0; k < 3; k++) wait_trig("t6_trig_seen", 120);
        enable = 1'b0;
        wait_quiet("t6_quiet", 100);
        chk("t6_xfers", 32'(xfer_count - x0), 32'd1);

        // randomized run
        do_reset(3);
        ready_mode = 1;
        x0 = xfer_count;
        enable = 1'b1;
        for (int a = 0; a < 12; a++) begin
            period = 16'($urandom_range(30, 90));
            for (int b = 0; b < 4; b++) begin
                lat = $urandom_range(2, 20);
                wait_trig("rnd_trig_seen", 200);
            end
        end
        enable = 1'b0;
        wait_quiet("rnd_quiet", 100);
        repeat (30) step();
        chk("rnd_xfers", 32'(xfer_count - x0), 32'd12);
        chk("rnd_sb_empty", 32'(exp_q.size()), 32'd0);
        chk("rnd_overrun", 32'(overrun), 32'd0);
        chk("rnd_timeout", 32'(timeout_err), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
